// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC handshake, single-outstanding imem requests,
// fetch queue to decode. Optional misaligned-PC trap: IFU_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int FETCH_WIDTH      = 32,
  parameter int QUEUE_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  input  logic                          clk_en,
  input  logic [INSTR_ADDR_WIDTH-1:0]   pc_addr,
  input  logic                          pc_valid,
  output logic                          pc_ready,
  input  logic                          redirect,
  output logic                          imem_req_valid,
  output logic [INSTR_ADDR_WIDTH-1:0]   imem_req_addr,
  input  logic                          imem_req_ready,
  input  logic                          imem_rsp_valid,
  input  logic [FETCH_WIDTH-1:0]        imem_rsp_data,
  input  logic                          imem_rsp_err,
  output logic                          instr_valid,
  output logic [FETCH_WIDTH-1:0]        instr_data,
  output logic [INSTR_ADDR_WIDTH-1:0]   instr_addr,
  output logic                          instr_err,
  input  logic                          instr_ready,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                      state_q, state_d;
  logic [INSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                        discard_q, discard_d;

  logic [INSTR_ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0]      q_data [QUEUE_DEPTH];
  logic                        q_err  [QUEUE_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count_q;

  logic                        room;
  logic                        accept;
  logic                        req_v;
  logic                        push;
  logic                        pop;
  logic [INSTR_ADDR_WIDTH-1:0] push_addr;
  logic [FETCH_WIDTH-1:0]      push_data;
  logic                        push_err;

`ifdef IFU_ALIGN_CHECK_EN
  logic                        align_q, align_d;
  // A pending trap entry holds a queue slot until it is pushed
  assign room = (count_q + CW'(align_q)) < FULL;
`else
  assign room = count_q < FULL;
`endif

  assign pc_ready = clk_en & ~redirect & room & (state_q == S_IDLE);
  assign pop      = instr_ready & (count_q != '0) & ~redirect;

  // Next-state, request and queue-push decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    accept    = 1'b0;
    req_v     = 1'b0;
    push      = 1'b0;
    push_addr = addr_q;
    push_data = '0;
    push_err  = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    align_d   = 1'b0;
    if (align_q) begin
      push     = ~redirect;
      push_err = 1'b1;
    end
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pc_valid & pc_ready) begin
          accept = 1'b1;
          addr_d = pc_addr;
`ifdef IFU_ALIGN_CHECK_EN
          if (pc_addr[0]) begin
            align_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        req_v = clk_en;
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
        if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push      = ~discard_q & ~redirect;
          push_data = imem_rsp_data;
          push_err  = imem_rsp_err;
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch FSM, request address and discard flag
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  // Misaligned-PC trap pending for next-cycle push
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      align_q <= 1'b0;
    end else if (clk_en) begin
      align_q <= align_d;
    end
  end
`endif

  // Circular fetch queue; redirect empties it
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_err[i]  <= 1'b0;
      end
    end else if (clk_en) begin
      if (redirect) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          q_addr[wr_ptr] <= push_addr;
          q_data[wr_ptr] <= push_data;
          q_err[wr_ptr]  <= push_err;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign imem_req_valid = req_v;
  assign imem_req_addr  = addr_q;
  assign instr_valid    = clk_en & (count_q != '0);
  assign instr_data     = q_data[rd_ptr];
  assign instr_addr     = q_addr[rd_ptr];
  assign instr_err      = q_err[rd_ptr];
  assign queue_count    = count_q;

  logic unused;
  assign unused = accept;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Covers latency, backpressure, redirect, stall/error, alignment.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        clk_en;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        instr_err;
  logic        instr_ready;
  logic [2:0]  queue_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .clk_en         (clk_en),
    .pc_addr        (pc_addr),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_addr     (instr_addr),
    .instr_err      (instr_err),
    .instr_ready    (instr_ready),
    .queue_count    (queue_count)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
  endtask

  // Full fetch: accept, request with ready, response next cycle
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input logic e);
    int n;
    n = 0;
    pc_addr  = a;
    pc_valid = 1'b1;
    #1;
    while (!pc_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (!pc_ready) begin
      check("fetch_accept", 64'(pc_ready), 64'd1);
      pc_valid = 1'b0;
      return;
    end
    tick();
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("fetch_req_addr", 64'(imem_req_addr), 64'(a));
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    imem_rsp_err   = e;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sync_rst       = 1'b1;
    clk_en         = 1'b1;
    pc_addr        = '0;
    pc_valid       = 1'b0;
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    instr_ready    = 1'b0;
    tick();
    tick();
    sync_rst = 1'b0;
    #1;

    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_count", 64'(queue_count), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'd0);
    check("rst_instr_data", 64'(instr_data), 64'd0);
    check("rst_instr_addr", 64'(instr_addr), 64'd0);
    check("rst_instr_err", 64'(instr_err), 64'd0);

    // Basic fetch latency: accept at N
    pc_addr  = 32'h100;
    pc_valid = 1'b1;
    #1;
    check("basic_pc_ready", 64'(pc_ready), 64'd1);
    tick();
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("basic_req_valid", 64'(imem_req_valid), 64'd1);
    check("basic_req_addr", 64'(imem_req_addr), 64'h100);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    #1;
    check("basic_n2_req_valid", 64'(imem_req_valid), 64'd0);
    check("basic_n2_instr_valid", 64'(instr_valid), 64'd0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("basic_instr_valid", 64'(instr_valid), 64'd1);
    check("basic_instr_data", 64'(instr_data), 64'hDEADBEEF);
    check("basic_instr_addr", 64'(instr_addr), 64'h100);
    check("basic_instr_err", 64'(instr_err), 64'd0);
    check("basic_count", 64'(queue_count), 64'd1);
    pop();
    check("basic_pop_count", 64'(queue_count), 64'd0);

    // Pop when empty is ignored
    pop();
    check("empty_pop_count", 64'(queue_count), 64'd0);

    // Backpressure: fill the queue
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 32'h1000 + 32'(i), 1'b0);
    end
    check("bp_count_full", 64'(queue_count), 64'd4);
    pc_addr  = 32'h10;
    pc_valid = 1'b1;
    #1;
    check("bp_pc_ready_full", 64'(pc_ready), 64'd0);
    pc_valid = 1'b0;
    check("bp_head0_addr", 64'(instr_addr), 64'h0);
    pop();
    check("bp_pc_ready_after_pop", 64'(pc_ready), 64'd1);
    check("bp_count_after_pop", 64'(queue_count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      check("bp_head_addr", 64'(instr_addr), 64'(i * 4));
      check("bp_head_data", 64'(instr_data), 64'(32'h1000 + 32'(i)));
      pop();
    end
    check("bp_drained", 64'(queue_count), 64'd0);

    // Redirect while 0x20 outstanding
    fetch(32'h40, 32'h4040, 1'b0);
    check("rw_pre_count", 64'(queue_count), 64'd1);
    pc_addr  = 32'h20;
    pc_valid = 1'b1;
    tick();
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    #1;
    check("rw_pc_ready_redirect", 64'(pc_ready), 64'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("rw_count_flushed", 64'(queue_count), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("rw_stale_dropped", 64'(queue_count), 64'd0);
    check("rw_instr_valid", 64'(instr_valid), 64'd0);
    fetch(32'h80, 32'h80808080, 1'b0);
    check("rw_new_addr", 64'(instr_addr), 64'h80);
    check("rw_new_data", 64'(instr_data), 64'h80808080);
    pop();

    // Redirect in the same cycle as the response
    pc_addr  = 32'h30;
    pc_valid = 1'b1;
    tick();
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h33333333;
    redirect       = 1'b1;
    #1;
    check("rc_pc_ready", 64'(pc_ready), 64'd0);
    tick();
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    #1;
    check("rc_count", 64'(queue_count), 64'd0);
    check("rc_instr_valid", 64'(instr_valid), 64'd0);
    check("rc_idle_ready", 64'(pc_ready), 64'd1);
    fetch(32'h90, 32'h90909090, 1'b0);
    check("rc_next_addr", 64'(instr_addr), 64'h90);
    pop();

    // Memory stall then error response
    pc_addr  = 32'h200;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req_valid", 64'(imem_req_valid), 64'd1);
      check("stall_req_addr", 64'(imem_req_addr), 64'h200);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h55;
    imem_rsp_err   = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    #1;
    check("err_valid", 64'(instr_valid), 64'd1);
    check("err_addr", 64'(instr_addr), 64'h200);
    check("err_flag", 64'(instr_err), 64'd1);
    pop();

    // Clock enable low freezes state and gates valids
    fetch(32'h300, 32'h3030, 1'b0);
    clk_en      = 1'b0;
    instr_ready = 1'b1;
    pc_valid    = 1'b1;
    #1;
    check("ce_pc_ready", 64'(pc_ready), 64'd0);
    check("ce_instr_valid", 64'(instr_valid), 64'd0);
    tick();
    tick();
    check("ce_count_held", 64'(queue_count), 64'd1);
    instr_ready = 1'b0;
    pc_valid    = 1'b0;
    clk_en      = 1'b1;
    #1;
    check("ce_resume_valid", 64'(instr_valid), 64'd1);
    check("ce_resume_addr", 64'(instr_addr), 64'h300);
    pop();

    // Misaligned PC
`ifdef IFU_ALIGN_CHECK_EN
    pc_addr  = 32'h101;
    pc_valid = 1'b1;
    #1;
    check("al_pc_ready", 64'(pc_ready), 64'd1);
    tick();
    pc_valid = 1'b0;
    #1;
    check("al_req_valid_1", 64'(imem_req_valid), 64'd0);
    tick();
    #1;
    check("al_req_valid_2", 64'(imem_req_valid), 64'd0);
    check("al_valid", 64'(instr_valid), 64'd1);
    check("al_addr", 64'(instr_addr), 64'h101);
    check("al_data", 64'(instr_data), 64'd0);
    check("al_err", 64'(instr_err), 64'd1);
    pop();
`else
    fetch(32'h101, 32'h11112222, 1'b0);
    check("al_addr", 64'(instr_addr), 64'h101);
    check("al_data", 64'(instr_data), 64'h11112222);
    check("al_err", 64'(instr_err), 64'd0);
    pop();
`endif
    check("final_count", 64'(queue_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program counter's next-address interface.
- Accepts fetch addresses from the PC and issues single-outstanding requests to instruction memory.
- Buffers returned fetch words with their addresses in a small queue that feeds decode.
- Raises backpressure (pc_ready low) so the PC stalls, and flushes queued and in-flight fetches on a branch/jump redirect.

Parameters:
INSTR_ADDR_WIDTH, 32, fetch address width (byte address)
FETCH_WIDTH, 32, bits returned per memory fetch
QUEUE_DEPTH, 4, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock
sync_rst  in  1  synchronous reset, active-high
clk_en  in  1  clock enable; all state holds when low
pc_addr  in  INSTR_ADDR_WIDTH  fetch address from program counter
pc_valid  in  1  pc_addr valid
pc_ready  out  1  address accepted this cycle; low = PC must stall
redirect  in  1  branch/jump taken: flush queue, discard in-flight response
imem_req_valid  out  1  memory request valid
imem_req_addr  out  INSTR_ADDR_WIDTH  memory request address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  memory response valid (one per accepted request)
imem_rsp_data  in  FETCH_WIDTH  fetched word
imem_rsp_err  in  1  bus/access error
instr_valid  out  1  queue head valid
instr_data  out  FETCH_WIDTH  queue head data
instr_addr  out  INSTR_ADDR_WIDTH  queue head address
instr_err  out  1  queue head error flag
instr_ready  in  1  decode pops head
queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset values: state IDLE, queue empty, discard flag 0. All valid outputs 0; queue_count 0; imem_req_addr, instr_data, instr_addr 0; instr_err 0.
- clk_en low: no register updates. pc_ready, imem_req_valid and instr_valid are forced 0. The memory must not return a response while clk_en is low.
- FSM IDLE:
  - pc_ready = clk_en & !redirect & (queue_count < QUEUE_DEPTH).
  - On pc_valid & pc_ready: latch address -> REQ.
  - The slot is reserved, so a push can never overflow the queue.
- FSM REQ:
  - imem_req_valid=1 and imem_req_addr is held stable until imem_req_ready.
  - On ready -> WAIT.
  - A request that has been presented is never withdrawn.
- FSM WAIT:
  - On imem_rsp_valid, push {addr, data, err} unless the discard flag is set. Clear the discard flag -> IDLE.
- Redirect:
  - Clears the queue this cycle; queue_count=0 the next cycle.
  - Sets the discard flag if the state is REQ or WAIT.
  - A response arriving in the same cycle as redirect is discarded.
  - A pop in the same cycle as redirect is ignored.
  - The new target is accepted no earlier than the next cycle.
- Latency:
  - pc accepted at cycle N -> imem_req_valid at N+1.
  - With ready at N+1 and response at N+2, instr_valid=1 at N+3 (queue output registered).
  - Best-case throughput is 1 fetch per 3 cycles.
- Queue:
  - Circular FIFO; pointers wrap modulo QUEUE_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - A pop when empty is ignored.
  - Head outputs hold while instr_valid & !instr_ready.
- Reset mid-transaction: the FSM returns to IDLE and the discard flag clears. A memory response that arrives after reset in IDLE is ignored; the memory is also reset in the same domain.
- Error responses are queued normally with instr_err=1 and do not stop fetching.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined: a pc_addr with bit 0 = 1 (instructions are 2-byte aligned) is accepted but no memory request is issued. Instead, an entry {addr, data=0, err=1} is pushed the cycle after acceptance and the FSM stays IDLE.
- Undefined: bit 0 is not checked and the address is forwarded to memory unchanged.

Test Plan:
- Basic fetch:
  - Stimulus: reset then pc_addr=0x00000100 valid, memory ready immediately, response 0xDEADBEEF after 1 cycle.
  - Required: instr_valid at cycle N+3 with data 0xDEADBEEF, addr 0x100, err 0, queue_count=1.
- Backpressure:
  - Stimulus: instr_ready=0, 4 fetches at 0x0/0x4/0x8/0xC.
  - Required: queue_count=4 and pc_ready=0 on the 5th. One pop restores pc_ready=1 the next cycle. Pop order is 0x0, 0x4, 0x8, 0xC.
- Redirect in WAIT:
  - Stimulus: redirect while a response for 0x20 is outstanding, then pc_addr=0x80.
  - Required: the 0x20 response is dropped, queue_count=0, and the first popped entry is addr 0x80.
- Redirect coincident with response:
  - Stimulus: imem_rsp_valid and redirect in the same cycle.
  - Required: nothing is pushed, and pc_ready=0 that cycle.
- Memory stall and error:
  - Stimulus: imem_req_ready low for 5 cycles, then a response with imem_rsp_err=1.
  - Required: imem_req_addr is stable all 5 cycles, and the entry pops with err=1.
- Alignment (IFU_ALIGN_CHECK_EN):
  - Stimulus: pc_addr=0x101.
  - Required: imem_req_valid never asserts; entry {0x101, 0, err=1} is queued. Without the macro, the request is issued with addr 0x101.
